// File: rtl/reg_alu_pkg.sv
// rtl/reg_alu_pkg.sv - shared types and constants for the register-file/ALU sequencer
package reg_alu_pkg;

  localparam int PKG_DATA_W = 8;
  localparam int PKG_ADDR_W = 4;
  localparam int PKG_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_t;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  typedef struct packed {
    logic [1:0]            alu_ctl;
    logic                  alu_src;
    logic                  wb_en;
    logic [PKG_ADDR_W-1:0] rd;
    logic [PKG_ADDR_W-1:0] rs1;
    logic [PKG_ADDR_W-1:0] rs2;
    logic [PKG_DATA_W-1:0] imm;
  } instr_t;

endpackage

// File: rtl/reg_alu_sequencer.sv
// rtl/reg_alu_sequencer.sv - single-issue IDLE/EXEC/RESP controller for the register-file + ALU datapath
module reg_alu_sequencer
  import reg_alu_pkg::*;
#(
  parameter int DATA_W = PKG_DATA_W,
  parameter int ADDR_W = PKG_ADDR_W,
  parameter int CNT_W  = PKG_CNT_W
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           instr_valid,
  output logic                           instr_ready,
  input  logic [4+3*ADDR_W+DATA_W-1:0]   instr,
  output logic [ADDR_W-1:0]              RA1,
  output logic [ADDR_W-1:0]              RA2,
  output logic [ADDR_W-1:0]              WA,
  output logic                           write_enable,
  output logic                           ALUSrc,
  output logic [1:0]                     ALUControl,
  output logic [DATA_W-1:0]              immediate,
  input  logic [DATA_W-1:0]              ALUResult,
  input  logic                           Zero,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [DATA_W-1:0]              res_data,
  output logic                           res_zero,
  output logic                           busy,
  output logic [CNT_W-1:0]               retired
);

  localparam int INSTR_W = 4 + 3*ADDR_W + DATA_W;

  seq_state_t          r_state;
  seq_state_t          w_next_state;
  instr_t              r_instr;
  logic [DATA_W-1:0]   r_res_data;
  logic                r_res_zero;
  logic [CNT_W-1:0]    r_retired;
  logic                w_accept;
  logic                w_retire;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_instr    <= '0;
      r_res_data <= '0;
      r_res_zero <= 1'b0;
      r_retired  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_instr <= instr_t'(instr[INSTR_W-1:0]);
      end
      // The datapath write and the result capture share the edge that ends EXEC.
      if (r_state == EXEC) begin
        r_res_data <= ALUResult;
        r_res_zero <= Zero;
      end
      if (w_retire) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  // Datapath controls decode from state so an async reset drops write_enable at once.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_retire     = 1'b0;
    instr_ready  = 1'b0;
    res_valid    = 1'b0;
    busy         = 1'b1;
    RA1          = '0;
    RA2          = '0;
    WA           = '0;
    write_enable = 1'b0;
    ALUSrc       = 1'b0;
    ALUControl   = 2'b00;
    immediate    = '0;
    case (r_state)
      IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) begin
          w_accept     = 1'b1;
          w_next_state = EXEC;
        end
      end
      EXEC: begin
        RA1          = r_instr.rs1;
        RA2          = r_instr.rs2;
        WA           = r_instr.rd;
        ALUSrc       = r_instr.alu_src;
        ALUControl   = r_instr.alu_ctl;
        immediate    = r_instr.imm;
        write_enable = r_instr.wb_en & (r_instr.rd != '0);
        w_next_state = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_retire     = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign res_data = r_res_data;
  assign res_zero = r_res_zero;
  assign retired  = r_retired;

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// tb/tb_reg_alu_sequencer.sv - randomized bench for reg_alu_sequencer with a behavioural datapath and instruction-level model
module tb_reg_alu_sequencer;
  import reg_alu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [23:0] instr = '0;
  logic [3:0]  RA1, RA2, WA;
  logic        write_enable, ALUSrc;
  logic [1:0]  ALUControl;
  logic [7:0]  immediate;
  logic [7:0]  ALUResult;
  logic        Zero;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [7:0]  res_data;
  logic        res_zero;
  logic        busy;
  logic [15:0] retired;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  model_regs [16];
  int          model_ret = 0;
  logic [7:0]  last_data;
  logic        last_zero;

  logic [7:0]  dp_regs [16];
  logic        dp_clear = 1'b1;
  logic [7:0]  dp_a, dp_b;

  always #5 CLK = ~CLK;

  reg_alu_sequencer dut (
    .CLK(CLK), .RST(RST),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .RA1(RA1), .RA2(RA2), .WA(WA), .write_enable(write_enable),
    .ALUSrc(ALUSrc), .ALUControl(ALUControl), .immediate(immediate),
    .ALUResult(ALUResult), .Zero(Zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero),
    .busy(busy), .retired(retired)
  );

  // Stand-in for the reg_file_alu datapath: x0 reads zero, write on the clock edge.
  always_comb begin
    dp_a = (RA1 == 4'd0) ? 8'd0 : dp_regs[RA1];
    dp_b = ALUSrc ? immediate : ((RA2 == 4'd0) ? 8'd0 : dp_regs[RA2]);
    ALUResult = 8'd0;
    case (ALUControl)
      ALU_AND: ALUResult = dp_a & dp_b;
      ALU_OR:  ALUResult = dp_a | dp_b;
      ALU_ADD: ALUResult = dp_a + dp_b;
      ALU_SUB: ALUResult = dp_a - dp_b;
      default: ALUResult = 8'd0;
    endcase
    Zero = (ALUResult == 8'd0);
  end

  always @(posedge CLK) begin
    if (dp_clear) begin
      for (int i = 0; i < 16; i++) dp_regs[i] <= 8'd0;
    end else if (write_enable && WA != 4'd0) begin
      dp_regs[WA] <= ALUResult;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int r;
    case (op)
      2'd0: r = int'(a) & int'(b);
      2'd1: r = int'(a) | int'(b);
      2'd2: r = int'(a) + int'(b);
      default: r = int'(a) - int'(b) + 256;
    endcase
    return 8'(r % 256);
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_outs"}, {RA1, RA2, WA, write_enable, ALUSrc, ALUControl, immediate,
                         res_valid, res_data, res_zero, busy, retired}, 64'd0);
    chk({tag, "_ready"}, 64'(instr_ready), 64'd1);
  endtask

  task automatic do_instr(input logic [1:0] op, input logic src, input logic wb,
                          input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                          input logic [7:0] imm, input int hold);
    logic [7:0] a, b, exp;
    int guard, lat;
    logic we_exp;
    a = (rs1 == 4'd0) ? 8'd0 : model_regs[rs1];
    b = src ? imm : ((rs2 == 4'd0) ? 8'd0 : model_regs[rs2]);
    exp = ref_op(op, a, b);
    we_exp = wb && (rd != 4'd0);
    guard = 0;
    while (!instr_ready && guard < 20) begin
      @(posedge CLK); #1; guard++;
    end
    chk("ready_wait", 64'(instr_ready), 64'd1);
    instr = {op, src, wb, rd, rs1, rs2, imm};
    instr_valid = 1'b1;
    @(posedge CLK); #1;
    instr_valid = 1'b0;
    lat = 1;
    chk("exec_ctl", {RA1, RA2, WA, ALUSrc, ALUControl, immediate, write_enable},
        {rs1, rs2, rd, src, op, imm, we_exp});
    while (!res_valid && lat < 10) begin
      @(posedge CLK); #1; lat++;
    end
    chk("latency", 64'(lat), 64'd2);
    chk("res_data", 64'(res_data), 64'(exp));
    chk("res_zero", 64'(res_zero), 64'(exp == 8'd0));
    chk("resp_ctl", {RA1, RA2, WA, write_enable, ALUSrc, ALUControl, immediate, instr_ready}, 64'd0);
    for (int h = 0; h < hold; h++) begin
      instr_valid = 1'b1;
      instr = 24'($urandom);
      @(posedge CLK); #1;
      chk("bp_valid", 64'(res_valid), 64'd1);
      chk("bp_data", 64'(res_data), 64'(exp));
      chk("bp_ready", 64'(instr_ready), 64'd0);
    end
    instr_valid = 1'b0;
    last_data = res_data;
    last_zero = res_zero;
    res_ready = 1'b1;
    @(posedge CLK); #1;
    res_ready = 1'b0;
    if (we_exp) model_regs[rd] = exp;
    model_ret++;
    chk("retired", 64'(retired), 64'(model_ret));
    chk("idle_after", {busy, res_valid, instr_ready}, 64'b001);
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    #1;
    check_reset_outputs("rst");
    @(posedge CLK); #1;
    RST = 1'b0;
    model_ret = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] old_val;
    for (int i = 0; i < 16; i++) model_regs[i] = 8'd0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("por");
    dp_clear = 1'b0;
    RST = 1'b0;

    for (int n = 0; n < 4; n++)
      do_instr(2'($urandom_range(0, 3)), 1'b1, 1'b1, 4'($urandom_range(1, 15)),
               4'($urandom), 4'($urandom), 8'($urandom), 0);

    // Reset while a result is pending in RESP
    instr = {ALU_ADD, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 8'd9};
    instr_valid = 1'b1;
    @(posedge CLK); #1;
    instr_valid = 1'b0;
    @(posedge CLK); #1;
    chk("pre_rst_valid", 64'(res_valid), 64'd1);
    pulse_reset();

    do_instr(ALU_ADD, 1'b1, 1'b1, 4'd3, 4'd0, 4'd0, 8'd7, 0);
    do_instr(ALU_ADD, 1'b1, 1'b0, 4'd0, 4'd3, 4'd0, 8'd0, 0);
    chk("raw_data", 64'(last_data), 64'd7);
    chk("raw_zero", 64'(last_zero), 64'd0);
    chk("raw_retired", 64'(retired), 64'd2);

    do_instr(ALU_ADD, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 8'd5, 0);
    do_instr(ALU_ADD, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 8'd0, 0);
    chk("x0_data", 64'(last_data), 64'd0);
    chk("x0_zero", 64'(last_zero), 64'd1);

    do_instr(ALU_SUB, 1'b1, 1'b0, 4'd0, 4'd3, 4'd0, 8'd2, 5);
    chk("bp_result", 64'(last_data), 64'd5);

    pulse_reset();
    for (int i = 1; i < 16; i++) do_instr(ALU_ADD, 1'b1, 1'b1, 4'(i), 4'd0, 4'd0, 8'(i), 0);
    for (int i = 1; i < 16; i++) begin
      do_instr(ALU_ADD, 1'b1, 1'b0, 4'd0, 4'(i), 4'd0, 8'd0, 0);
      chk("sweep_data", 64'(last_data), 64'(i));
    end
    chk("sweep_retired", 64'(retired), 64'd30);

    for (int n = 0; n < 40; n++)
      do_instr(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 4'($urandom),
               4'($urandom), 4'($urandom), 8'($urandom), int'($urandom_range(0, 2)));

    // Reset lands while the write to r5 is being presented
    old_val = model_regs[5];
    while (!instr_ready) begin
      @(posedge CLK); #1;
    end
    instr = {ALU_ADD, 1'b1, 1'b1, 4'd5, 4'd0, 4'd0, old_val + 8'd1};
    instr_valid = 1'b1;
    @(posedge CLK); #1;
    instr_valid = 1'b0;
    chk("exec_we", 64'(write_enable), 64'd1);
    RST = 1'b1;
    #1;
    chk("async_we_drop", 64'(write_enable), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    #2;
    RST = 1'b0;
    model_ret = 0;
    @(posedge CLK); #1;
    do_instr(ALU_OR, 1'b1, 1'b0, 4'd0, 4'd5, 4'd0, 8'd0, 0);
    chk("async_keep", 64'(last_data), 64'(old_val));
    chk("async_retired", 64'(retired), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
